// File: rtl/dsp_tree_pkg.sv
// Shared constants for the DSP operator tree and its drain stage.
// Provides the default tree geometry and a ceiling-log2 helper for pointer sizing.
package dsp_tree_pkg;

   localparam int DSP_TREE_WIDTH   = 8;
   localparam int DSP_TREE_LATENCY = 3;  // mul + add + add
   localparam int DSP_TREE_DEPTH   = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dsp_tree_fifo.sv
// Synchronous FIFO with registered wrap-around pointers and an occupancy count.
// Callers must not push when full or pop when empty.
module dsp_tree_fifo
   import dsp_tree_pkg::*;
#(
   parameter int width = DSP_TREE_WIDTH,
   parameter int depth = DSP_TREE_DEPTH,
   localparam int PW   = clog2(depth)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count
);

   logic [width-1:0] mem_q [depth];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;

   assign full  = (cnt_q == (PW+1)'(depth));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   // Storage is never reset, so the head is masked while nothing is held.
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/dsp_tree_sink.sv
// Drain stage for the fixed-latency DSP tree: tracks in-flight issues, buffers results, issues credit.
// Optional pop counter `results` is built when DSP_TREE_SINK_STATS_EN is defined.
module dsp_tree_sink
   import dsp_tree_pkg::*;
#(
   parameter int width   = DSP_TREE_WIDTH,
   parameter int latency = DSP_TREE_LATENCY,
   parameter int depth   = DSP_TREE_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data,
   output logic             overrun
`ifdef DSP_TREE_SINK_STATS_EN
   ,
   output logic [15:0]      results
`endif
);

   localparam int PW = clog2(depth);
   localparam int CW = clog2(depth + latency + 1);

   logic [latency-1:0] vpipe_q, vpipe_d;
   logic               overrun_q, overrun_d;
   logic               accept, push, pop, full, empty;
   logic [PW:0]        occ;
   logic [CW-1:0]      credit;

   function automatic logic [CW-1:0] popcount(input logic [latency-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int k = 0; k < latency; k++) n = n + CW'(v[k]);
      return n;
   endfunction

   // Credit counts buffered plus in-flight results; a pop frees credit only next cycle.
   assign credit    = CW'(occ) + popcount(vpipe_q);
   assign in_ready  = (credit < CW'(depth));
   assign accept    = in_valid & in_ready;
   assign push      = vpipe_q[latency-1] & ~full;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign overrun   = overrun_q;

   always_comb begin
      vpipe_d    = vpipe_q << 1;
      vpipe_d[0] = accept;
      overrun_d  = overrun_q | (in_valid & ~in_ready);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         vpipe_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         vpipe_q   <= vpipe_d;
         overrun_q <= overrun_d;
      end
   end

   dsp_tree_fifo #(
      .width (width),
      .depth (depth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (y_in),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .count (occ)
   );

`ifdef DSP_TREE_SINK_STATS_EN
   logic [15:0] results_q, results_d;

   assign results_d = results_q + 16'(pop);
   assign results   = results_q;

   always_ff @(posedge clock) begin
      if (!reset) results_q <= '0;
      else        results_q <= results_d;
   end
`endif

endmodule

// File: tb/tb_dsp_tree_sink.sv
// Self-checking bench for dsp_tree_sink against a timestamp/queue reference model.
module tb_dsp_tree_sink;

   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] y_in = 8'h00;
   logic       in_ready, out_valid, overrun;
   logic [7:0] out_data;
`ifdef DSP_TREE_SINK_STATS_EN
   logic [15:0] results;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   dsp_tree_sink dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .overrun   (overrun)
`ifdef DSP_TREE_SINK_STATS_EN
      ,
      .results   (results)
`endif
   );

   // Reference model: FIFO contents as a queue, tree results scheduled by issue time.
   logic [7:0] m_fifo[$];
   bit         s_vld[16];
   logic [7:0] s_val[16];
   int         m_inflight = 0;
   int         cyc = 0;
   int         m_pops = 0;
   bit         m_ovr = 1'b0;

   function automatic bit m_ready();
      return (m_fifo.size() + m_inflight) < DEPTH;
   endfunction

   function automatic logic [7:0] m_head();
      return (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
   endfunction

   task automatic m_clear();
      m_fifo.delete();
      for (int i = 0; i < 16; i++) s_vld[i] = 1'b0;
      m_inflight = 0;
      m_ovr = 1'b0;
      m_pops = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      m_clear();
      cyc++;
   endtask

   // Drive one cycle; the tree delivers an accepted issue's value on y_in LAT cycles later.
   task automatic step(input bit iv, input bit ordy, input logic [7:0] val);
      int slot;
      bit rdy;
      slot = cyc % 16;
      rdy = m_ready();
      in_valid = iv;
      out_ready = ordy;
      y_in = s_vld[slot] ? s_val[slot] : 8'($urandom);
      if (iv && !rdy) m_ovr = 1'b1;
      if (ordy && m_fifo.size() != 0) begin
         void'(m_fifo.pop_front());
         m_pops++;
      end
      if (s_vld[slot]) begin
         m_fifo.push_back(s_val[slot]);
         s_vld[slot] = 1'b0;
         m_inflight--;
      end
      if (iv && rdy) begin
         s_vld[(cyc + LAT) % 16] = 1'b1;
         s_val[(cyc + LAT) % 16] = val;
         m_inflight++;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
`ifdef DSP_TREE_SINK_STATS_EN
      checks++;
      if (results !== 16'd0) begin failures++; $display("FAIL reset_results got=%0d exp=0", results); end
`endif
   endtask

   task automatic test_single();
      step(1'b1, 1'b1, 8'h5A);
      for (int k = 1; k <= LAT; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid T+%0d got=%b exp=0", k, out_valid); end
         step(1'b0, 1'b1, 8'h00);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
         failures++;
         $display("FAIL single_result valid=%b data=%h exp valid=1 data=5a", out_valid, out_data);
      end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL single_popped got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL mid_reset_overrun got=%b exp=0", overrun); end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_stale cycle=%0d got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (overrun !== m_ovr) begin failures++; $display("FAIL bp_overrun cycle=%0d got=%b exp=%b", i, overrun, m_ovr); end
         if (in_ready === 1'b1) acc++;
         step(1'b1, 1'b0, 8'(acc));
      end
      checks++;
      if (acc != DEPTH) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc, DEPTH); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      checks++;
      if (overrun !== 1'b1) begin failures++; $display("FAIL bp_forced_overrun got=%b exp=1", overrun); end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
            failures++;
            $display("FAIL bp_drain idx=%0d valid=%b data=%0d exp valid=1 data=%0d", i, out_valid, out_data, i);
         end
         step(1'b0, 1'b1, 8'h00);
      end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_entry got=%b exp=0", out_valid); end
      checks++;
      if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_wrap();
      int sent, got, budget;
      bit iv, ordy;
      sent = 0;
      got = 0;
      budget = 0;
      while (m_fifo.size() < 2 && budget < 50) begin
         iv = m_ready() && sent < 40;
         step(iv, 1'b0, 8'(sent));
         if (iv) sent++;
         budget++;
      end
      while (got < 40 && budget < 1000) begin
         ordy = ($urandom_range(0, 3) != 0);
         iv = m_ready() && sent < 40;
         checks++;
         if (in_ready !== m_ready()) begin failures++; $display("FAIL wrap_in_ready got=%b exp=%b", in_ready, m_ready()); end
         checks++;
         if (out_valid !== (m_fifo.size() != 0)) begin
            failures++;
            $display("FAIL wrap_out_valid got=%b exp=%b", out_valid, (m_fifo.size() != 0));
         end
         if (out_valid === 1'b1 && ordy) begin
            checks++;
            if (out_data !== 8'(got)) begin failures++; $display("FAIL wrap_order got=%0d exp=%0d", out_data, got); end
            got++;
         end
         step(iv, ordy, 8'(sent));
         if (iv) sent++;
         budget++;
      end
      checks++;
      if (got != 40) begin failures++; $display("FAIL wrap_count got=%0d exp=40", got); end
   endtask

   task automatic test_random();
      bit iv, ordy;
      for (int i = 0; i < 400; i++) begin
         iv = ($urandom_range(0, 2) != 0);
         ordy = ($urandom_range(0, 1) != 0);
         checks++;
         if (in_ready !== m_ready()) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, m_ready()); end
         checks++;
         if (out_valid !== (m_fifo.size() != 0)) begin
            failures++;
            $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, out_valid, (m_fifo.size() != 0));
         end
         if (m_fifo.size() != 0) begin
            checks++;
            if (out_data !== m_head()) begin failures++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", i, out_data, m_head()); end
         end
         checks++;
         if (overrun !== m_ovr) begin failures++; $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); end
         step(iv, ordy, 8'($urandom));
      end
   endtask

`ifdef DSP_TREE_SINK_STATS_EN
   task automatic test_stats();
      int budget;
      do_reset();
      checks++;
      if (results !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", results); end
      budget = 0;
      while (m_pops < 70000 && budget < 95000) begin
         step(m_ready(), 1'b1, 8'($urandom));
         budget++;
      end
      checks++;
      if (m_pops != 70000) begin failures++; $display("FAIL stats_budget pops=%0d exp=70000", m_pops); end
      checks++;
      if (results !== 16'd4464) begin failures++; $display("FAIL stats_results got=%0d exp=4464", results); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_reset_midstream();
      test_backpressure();
      do_reset();
      test_wrap();
      do_reset();
      test_random();
`ifdef DSP_TREE_SINK_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
